// File: rtl/exc_pkg.sv
// Shared constants for the exception sequencer: cause codes, CP0 status bit
// positions, exception vector and FSM state encoding.
package exc_pkg;

    localparam logic [31:0] VECTOR_ADDR = 32'h0000_0004;

    localparam logic [4:0] CAUSE_SYSCALL = 5'd8;
    localparam logic [4:0] CAUSE_BREAK   = 5'd9;
    localparam logic [4:0] CAUSE_TEQ     = 5'd13;
    localparam logic [4:0] CAUSE_INT     = 5'd0;

    localparam int IE  = 0;
    localparam int SYS = 1;
    localparam int BRK = 2;
    localparam int TEQ = 3;
    localparam int INT = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COMMIT   = 2'd1,
        REDIRECT = 2'd2
    } state_t;

endpackage

// File: rtl/exc_prio_enc.sv
// Masks decoder exception requests with CP0 status and picks a single winner:
// break > syscall > teq > eret (> int_req when EXC_INT_EN is defined).
module exc_prio_enc
    import exc_pkg::*;
(
    input  logic        syscall_req,
    input  logic        break_req,
    input  logic        teq_req,
    input  logic        eret_req,
`ifdef EXC_INT_EN
    input  logic        int_req,
`endif
    input  logic [31:0] status,
    output logic        valid,
    output logic [4:0]  cause,
    output logic        is_eret
);

    logic ie;
    assign ie = status[IE];

`ifdef EXC_INT_EN
    logic unused_status;
    assign unused_status = ^status[31:5];
`else
    logic unused_status;
    assign unused_status = ^status[31:4];
`endif

    always_comb begin
        valid   = 1'b0;
        cause   = 5'd0;
        is_eret = 1'b0;
        if (break_req && ie && status[BRK]) begin
            valid = 1'b1;
            cause = CAUSE_BREAK;
        end else if (syscall_req && ie && status[SYS]) begin
            valid = 1'b1;
            cause = CAUSE_SYSCALL;
        end else if (teq_req && ie && status[TEQ]) begin
            valid = 1'b1;
            cause = CAUSE_TEQ;
        end else if (eret_req) begin
            // eret is never masked; its cause field is unused by CP0
            valid   = 1'b1;
            is_eret = 1'b1;
        end
`ifdef EXC_INT_EN
        else if (int_req && ie && status[INT]) begin
            valid = 1'b1;
            cause = CAUSE_INT;
        end
`endif
    end

endmodule

// File: rtl/exc_ctrl.sv
// Exception/eret sequencer: IDLE -> COMMIT (CP0 strobe) -> REDIRECT (PC load).
// Optional external interrupt source enabled by defining EXC_INT_EN.
module exc_ctrl
    import exc_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        syscall_req,
    input  logic        break_req,
    input  logic        teq_req,
    input  logic        eret_req,
`ifdef EXC_INT_EN
    input  logic        int_req,
`endif
    input  logic [31:0] req_pc,
    input  logic [31:0] status,
    input  logic [31:0] epc,
    output logic        stall,
    output logic        cp0_exc,
    output logic        cp0_eret,
    output logic [4:0]  cp0_cause,
    output logic [31:0] cp0_pc,
    output logic        pc_redirect,
    output logic [31:0] redirect_addr,
    output logic        busy
);

    state_t      state, state_next;
    logic        enc_valid;
    logic [4:0]  enc_cause;
    logic        enc_is_eret;
    logic        accept;
    logic [4:0]  cause_q;
    logic [31:0] pc_q;
    logic        eret_q;

    exc_prio_enc u_prio_enc (
        .syscall_req (syscall_req),
        .break_req   (break_req),
        .teq_req     (teq_req),
        .eret_req    (eret_req),
`ifdef EXC_INT_EN
        .int_req     (int_req),
`endif
        .status      (status),
        .valid       (enc_valid),
        .cause       (enc_cause),
        .is_eret     (enc_is_eret)
    );

    // Gating with rst_n keeps the combinational stall low while reset is held.
    assign accept = (state == IDLE) && enc_valid && rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cause_q <= 5'd0;
            pc_q    <= 32'd0;
            eret_q  <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                cause_q <= enc_cause;
                pc_q    <= req_pc;
                eret_q  <= enc_is_eret;
            end
        end
    end

    always_comb begin
        state_next    = state;
        stall         = 1'b0;
        busy          = 1'b0;
        cp0_exc       = 1'b0;
        cp0_eret      = 1'b0;
        cp0_cause     = 5'd0;
        cp0_pc        = 32'd0;
        pc_redirect   = 1'b0;
        redirect_addr = 32'd0;
        case (state)
            IDLE: begin
                if (accept) begin
                    stall      = 1'b1;
                    state_next = COMMIT;
                end
            end
            COMMIT: begin
                stall      = 1'b1;
                busy       = 1'b1;
                cp0_exc    = 1'b1;
                cp0_eret   = eret_q;
                cp0_cause  = cause_q;
                cp0_pc     = pc_q;
                state_next = REDIRECT;
            end
            REDIRECT: begin
                stall         = 1'b1;
                busy          = 1'b1;
                pc_redirect   = 1'b1;
                // CP0 has already written EPC on the COMMIT negedge
                redirect_addr = eret_q ? epc : VECTOR_ADDR;
                state_next    = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule
